// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small input FIFO, programmable bit
// period, optional odd/even parity and 1 or 2 stop bits. Queued words are
// sent back-to-back with no idle gap between frames.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset; discards queued words
//   in_valid    producer offers in_data
//   in_data     word to transmit, LSB first
//   in_ready    FIFO can accept a word (fifo_count < FIFO_DEPTH)
//   tx          registered serial line, idles high
//   busy        registered, high while a frame is in progress
//   done        registered one-cycle pulse per completed frame
//   fifo_count  words currently queued
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  localparam bit PARAMS_OK = (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                             (CLKS_PER_BIT >= 1) && (PARITY <= 2) &&
                             ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                             (FIFO_DEPTH >= 2) &&
                             ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;

  // Frame engine
  state_t               state;
  logic [TMR_W-1:0]     timer;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;
  logic                 last_stop;
  logic                 last_data;

  // Ready depends on occupancy only: a full FIFO refuses even if a pop coincides.
  assign in_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr];

  assign bit_end   = (timer == TMR_W'(CLKS_PER_BIT - 1));
  assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));
  assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));

  // Pop when a frame starts: from idle, or at the end of the last stop bit.
  assign pop = (fifo_count != '0) &&
               ((state == S_IDLE) ||
                ((state == S_STOP) && bit_end && last_stop));

  // FIFO data array (no reset needed; pointers define validity)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame FSM; tx/busy/done are registered alongside each state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx      <= 1'b1;
          timer   <= '0;
          bit_idx <= '0;
          if (pop) begin
            shreg   <= head;
            par_bit <= (PARITY == 1) ? ~^head : ^head;
            state   <= S_START;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            tx      <= shreg[0];
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        // The shift register keeps the current bit at position 0.
        S_DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (last_data) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= S_STOP;
            tx      <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        // Last stop bit either chains straight into the next start bit or idles.
        S_STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (last_stop) begin
              done    <= 1'b1;
              bit_idx <= '0;
              if (pop) begin
                shreg   <= head;
                par_bit <= (PARITY == 1) ? ~^head : ^head;
                state   <= S_START;
                tx      <= 1'b0;
              end else begin
                state <= S_IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
          timer   <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  // Flag illegal parameter combinations in simulation
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (PARAMS_OK)
      else $error("uart_tx_fifo: illegal parameters DATA_BITS=%0d CLKS_PER_BIT=%0d PARITY=%0d STOP_BITS=%0d FIFO_DEPTH=%0d",
                  DATA_BITS, CLKS_PER_BIT, PARITY, STOP_BITS, FIFO_DEPTH);
    end
  end

endmodule
